// File: rtl/ulight_fifo_tc_pkg.sv
// ulight_fifo_tc_pkg: shared register map constants and helpers for the timecode capture block.
// Revision: 1.0
`default_nettype none

package ulight_fifo_tc_pkg;

  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_IRQ_MASK = 2'd2;
  localparam logic [1:0] REG_LAST     = 2'd3;

  localparam int STATUS_EMPTY_BIT = 16;
  localparam int STATUS_FULL_BIT  = 17;
  localparam int STATUS_OVF_BIT   = 18;

  localparam int VALID_BIT = 31;

  localparam int IRQ_NEMPTY_BIT = 0;
  localparam int IRQ_OVF_BIT    = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ulight_fifo_tc_fifo.sv
// ulight_fifo_tc_fifo: synchronous FIFO with combinational head output and occupancy level.
// Revision: 1.0
`default_nettype none

module ulight_fifo_tc_fifo
  import ulight_fifo_tc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W = clog2(FIFO_DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [LVL_W-1:0]      level_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q;
  logic                  do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(FIFO_DEPTH));
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ulight_fifo_timecode_rx_capture.sv
// ulight_fifo_timecode_rx_capture: Avalon-MM slave buffering SpaceWire time-codes with status and irq.
// Revision: 1.0
`default_nettype none

module ulight_fifo_timecode_rx_capture
  import ulight_fifo_tc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  input  logic                  in_valid,
  output logic                  irq
);

  localparam int LVL_W = clog2(FIFO_DEPTH) + 1;

  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;
  logic                  ovf_q, ovf_d;
  logic [1:0]            mask_q, mask_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic                  last_valid_q, last_valid_d;

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty, fifo_full;
  logic [LVL_W-1:0]      fifo_level, level_nx;
  logic                  w_pop, w_push;
  logic                  w_unused_wdata;

  assign w_unused_wdata = ^{writedata[31:19], writedata[17:2]};

  assign w_pop  = read & (address == REG_DATA) & ~fifo_empty;
  assign w_push = in_valid & (~fifo_full | w_pop);
  assign level_nx = fifo_level + LVL_W'(w_push) - LVL_W'(w_pop);

  ulight_fifo_tc_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (in_port),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  always_comb begin
    ovf_d        = ovf_q;
    mask_d       = mask_q;
    last_d       = last_q;
    last_valid_d = last_valid_q;
    rdata_d      = rdata_q;

    if (write && address == REG_STATUS && writedata[STATUS_OVF_BIT]) ovf_d = 1'b0;
    // Set after clear so a new overflow wins over a same-cycle clear.
    if (in_valid && fifo_full && !w_pop) ovf_d = 1'b1;
    if (write && address == REG_IRQ_MASK) mask_d = writedata[1:0];

    if (in_valid) begin
      last_d       = in_port;
      last_valid_d = 1'b1;
    end

    if (read) begin
      rdata_d = '0;
      case (address)
        REG_DATA: begin
          if (!fifo_empty) begin
            rdata_d[DATA_WIDTH-1:0] = fifo_dout;
            rdata_d[VALID_BIT]      = 1'b1;
          end
        end
        REG_STATUS: begin
          rdata_d[LVL_W-1:0]       = fifo_level;
          rdata_d[STATUS_EMPTY_BIT] = fifo_empty;
          rdata_d[STATUS_FULL_BIT]  = fifo_full;
          rdata_d[STATUS_OVF_BIT]   = ovf_q;
        end
        REG_IRQ_MASK: rdata_d[1:0] = mask_q;
        default: begin
          rdata_d[DATA_WIDTH-1:0] = last_q;
          rdata_d[VALID_BIT]      = last_valid_q;
        end
      endcase
    end

    irq_d = (mask_d[IRQ_NEMPTY_BIT] & (level_nx != '0)) | (mask_d[IRQ_OVF_BIT] & ovf_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q      <= '0;
      irq_q        <= 1'b0;
      ovf_q        <= 1'b0;
      mask_q       <= '0;
      last_q       <= '0;
      last_valid_q <= 1'b0;
    end else begin
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
      ovf_q        <= ovf_d;
      mask_q       <= mask_d;
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_ulight_fifo_timecode_rx_capture.sv
// tb_ulight_fifo_timecode_rx_capture: directed self-checking bench for the timecode capture block.
// Revision: 1.0
`default_nettype none

module tb_ulight_fifo_timecode_rx_capture;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic        in_valid;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] r;

  ulight_fifo_timecode_rx_capture #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .in_valid  (in_valid),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [7:0] v);
    in_valid = 1'b1;
    in_port  = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    read    = 1'b1;
    address = a;
    step();
    read = 1'b0;
    d    = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    write     = 1'b1;
    address   = a;
    writedata = d;
    step();
    write = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    address   = '0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = '0;
    in_port   = '0;
    in_valid  = 1'b0;
    step();
    step();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    step();

    // Basic reset state and empty read
    rd(2'd1, r); check("status_after_reset", r, 32'h0001_0000);
    rd(2'd0, r); check("data_empty", r, 32'h0);
    check("irq_idle", {31'd0, irq}, 32'h0);

    // Small burst in order
    tick(8'h05); tick(8'h06); tick(8'h07);
    rd(2'd0, r); check("pop_05", r, 32'h8000_0005);
    rd(2'd0, r); check("pop_06", r, 32'h8000_0006);
    rd(2'd0, r); check("pop_07", r, 32'h8000_0007);
    rd(2'd1, r); check("status_drained", r, 32'h0001_0000);
    rd(2'd3, r); check("last_07", r, 32'h8000_0007);

    // Overfill to depth+1
    for (int i = 0; i < 9; i++) tick(8'(8'h10 + i));
    rd(2'd1, r); check("status_full_ovf", r, 32'h0006_0008);
    for (int i = 0; i < 8; i++) begin
      rd(2'd0, r); check("drain_ovf", r, 32'h8000_0010 + 32'(i));
    end
    rd(2'd3, r); check("last_18", r, 32'h8000_0018);
    rd(2'd1, r); check("status_empty_ovf", r, 32'h0005_0000);
    wr(2'd1, 32'h0004_0000);
    rd(2'd1, r); check("status_ovf_cleared", r, 32'h0001_0000);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) tick(8'(8'h20 + i));
    in_valid = 1'b1; in_port = 8'h28; read = 1'b1; address = 2'd0;
    step();
    in_valid = 1'b0; read = 1'b0;
    check("full_push_pop_data", readdata, 32'h8000_0020);
    rd(2'd1, r); check("full_push_pop_status", r, 32'h0002_0008);
    tick(8'h29);
    rd(2'd1, r); check("overflow_set", r, 32'h0006_0008);
    wr(2'd1, 32'h0004_0000);
    rd(2'd1, r); check("overflow_w1c", r, 32'h0002_0008);
    write = 1'b1; address = 2'd1; writedata = 32'h0004_0000;
    in_valid = 1'b1; in_port = 8'h2F;
    step();
    write = 1'b0; in_valid = 1'b0;
    rd(2'd1, r); check("clear_vs_set", r, 32'h0006_0008);
    wr(2'd1, 32'h0004_0000);
    for (int i = 0; i < 8; i++) begin
      rd(2'd0, r); check("drain_pushpop", r, 32'h8000_0021 + 32'(i));
    end
    rd(2'd3, r); check("last_2f", r, 32'h8000_002F);

    // Empty FIFO with simultaneous push and pop: no bypass
    in_valid = 1'b1; in_port = 8'h33; read = 1'b1; address = 2'd0;
    step();
    in_valid = 1'b0; read = 1'b0;
    check("empty_push_pop_data", readdata, 32'h0);
    rd(2'd1, r); check("empty_push_pop_status", r, 32'h0000_0001);
    rd(2'd0, r); check("pop_33", r, 32'h8000_0033);

    // Interrupts
    wr(2'd2, 32'hFFFF_FFF1);
    rd(2'd2, r); check("irq_mask_rd", r, 32'h0000_0001);
    check("irq_masked_empty", {31'd0, irq}, 32'h0);
    tick(8'h2A);
    check("irq_nempty_edge", {31'd0, irq}, 32'h1);
    step();
    check("irq_nempty_hold", {31'd0, irq}, 32'h1);
    rd(2'd0, r); check("pop_2a", r, 32'h8000_002A);
    check("irq_after_pop", {31'd0, irq}, 32'h0);
    wr(2'd2, 32'h0000_0002);
    for (int i = 0; i < 8; i++) tick(8'(8'h30 + i));
    check("irq_ovf_mask_no_ovf", {31'd0, irq}, 32'h0);
    tick(8'h38);
    check("irq_ovf_set", {31'd0, irq}, 32'h1);
    step();
    check("irq_ovf_hold", {31'd0, irq}, 32'h1);
    wr(2'd1, 32'h0004_0000);
    check("irq_ovf_cleared", {31'd0, irq}, 32'h0);

    // Reset mid-burst with four entries queued
    for (int i = 0; i < 4; i++) begin
      rd(2'd0, r); check("drain_pre_reset", r, 32'h8000_0030 + 32'(i));
    end
    wr(2'd2, 32'h0000_0001);
    check("irq_pre_reset", {31'd0, irq}, 32'h1);
    rd(2'd1, r); check("status_pre_reset", r, 32'h0000_0004);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq", {31'd0, irq}, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    rd(2'd1, r); check("status_post_reset", r, 32'h0001_0000);
    rd(2'd2, r); check("mask_post_reset", r, 32'h0);
    rd(2'd3, r); check("last_post_reset", r, 32'h0);
    rd(2'd0, r); check("data_post_reset", r, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
